// File: rtl/jio_kbd_in_pkg.sv
// Shared definitions for jcscpu IO bus devices: addresses, status bit layout
// and IO cycle decoding.
package jio_pkg;

   localparam logic [7:0] TTY_ADDR      = 8'd0;
   localparam logic [7:0] KBD_DATA_ADDR = 8'd1;
   localparam logic [7:0] KBD_STAT_ADDR = 8'd2;

   localparam int STAT_READY = 7;
   localparam int STAT_OVF   = 6;
   localparam int STAT_FULL  = 5;

   typedef enum logic [1:0] {
      CYC_IN_DATA  = 2'b00,
      CYC_OUT_DATA = 2'b01,
      CYC_IN_ADDR  = 2'b10,
      CYC_OUT_ADDR = 2'b11
   } io_cycle_t;

   function automatic io_cycle_t decode_cycle(input logic io_da, input logic io_io);
      return io_cycle_t'({io_da, io_io});
   endfunction

endpackage

// File: rtl/jio_kbd_in_if.sv
// IO bus strobes and data as seen between the control unit and one IO device.
interface jio_io_if;

   logic       io_s;
   logic       io_e;
   logic       io_da;
   logic       io_io;
   logic [7:0] bus_in;
   logic [7:0] bus_out;

   modport master (output io_s, io_e, io_da, io_io, bus_in, input bus_out);
   modport slave  (input io_s, io_e, io_da, io_io, bus_in, output bus_out);

endinterface

// File: rtl/jio_kbd_in_jdebounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module jdebounce #(
   parameter int DB_CYCLES = 2
) (
   input  logic sclk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // The level flips only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge sclk) begin
      if (reset) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         pulse <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
               pulse <= sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/jio_kbd_in.sv
// Keyboard-style input device: debounced button pushes the switch byte into a
// FIFO that the CPU drains with IN Data; contributes 8'h00 to the wor bus when idle.
module jio_kbd_in
   import jio_pkg::*;
#(
   parameter logic [7:0] DATA_ADDR = KBD_DATA_ADDR,
   parameter logic [7:0] STAT_ADDR = KBD_STAT_ADDR,
   parameter int         DEPTH     = 4,
   parameter int         DB_CYCLES = 2
) (
   input  logic                 sclk,
   input  logic                 reset,
   input  logic [7:0]           sw_data,
   input  logic                 btn_push,
   jio_io_if.slave              io,
   output logic [$clog2(DEPTH):0] count,
   output logic                 overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [7:0]  sel;
   logic        rd_active;
   logic        rd_was_data;
   logic        btn_level;
   logic        push;
   logic        empty;
   logic        full;
   logic        rd_data;
   logic        rd_stat;
   logic        read_end;
   logic        pop;
   logic        push_ok;
   logic        stat_clear;
   logic        ovf_set;
   logic [7:0]  count8;
   logic [7:0]  status;
   io_cycle_t   cyc;

   jdebounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .sclk  (sclk),
      .reset (reset),
      .raw   (btn_push),
      .level (btn_level),
      .pulse (push)
   );

   assign cyc    = decode_cycle(io.io_da, io.io_io);
   assign count  = wptr - rptr;
   assign count8 = 8'(count);
   assign empty  = (wptr == rptr);
   assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   assign rd_data    = io.io_e && (cyc == CYC_IN_DATA) && (sel == DATA_ADDR);
   assign rd_stat    = io.io_e && (cyc == CYC_IN_DATA) && (sel == STAT_ADDR);
   assign read_end   = rd_active && !(rd_data || rd_stat);
   assign pop        = read_end && rd_was_data && !empty;
   assign stat_clear = read_end && !rd_was_data;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok    = push && (!full || pop);
   assign ovf_set    = push && full && !pop;

   always_comb begin
      status             = 8'h00;
      status[STAT_READY] = !empty;
      status[STAT_OVF]   = overflow;
      status[STAT_FULL]  = full;
      status[3:0]        = count8[3:0];
   end

   always_comb begin
      io.bus_out = 8'h00;
      if (rd_data) begin
         io.bus_out = empty ? 8'h00 : mem[rptr[AW-1:0]];
      end else if (rd_stat) begin
         io.bus_out = status;
      end
   end

   always_ff @(posedge sclk) begin
      if (!reset && push_ok) begin
         mem[wptr[AW-1:0]] <= sw_data;
      end
   end

   // Read-end is judged on the kind of read registered while io_e was high.
   always_ff @(posedge sclk) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         sel         <= 8'h00;
         rd_active   <= 1'b0;
         rd_was_data <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (io.io_s && (cyc == CYC_OUT_ADDR)) begin
            sel <= io.bus_in;
         end
         rd_active <= rd_data || rd_stat;
         if (rd_data || rd_stat) begin
            rd_was_data <= rd_data;
         end
         if (push_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (stat_clear) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jio_kbd_in.sv
// Scoreboard bench for jio_kbd_in: a queue-based model predicts each IN Data
// response and a negedge monitor compares whatever the device drives.
module tb_jio_kbd_in;
   import jio_pkg::*;

   localparam int DEPTH = 4;

   logic       sclk = 1'b0;
   logic       reset;
   logic [7:0] sw_data;
   logic       btn_push;
   logic [2:0] count;
   logic       overflow;

   jio_io_if io ();

   jio_kbd_in #(
      .DATA_ADDR (8'd1),
      .STAT_ADDR (8'd2),
      .DEPTH     (DEPTH),
      .DB_CYCLES (2)
   ) dut (
      .sclk     (sclk),
      .reset    (reset),
      .sw_data  (sw_data),
      .btn_push (btn_push),
      .io       (io),
      .count    (count),
      .overflow (overflow)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic [7:0] bus;
      int         cnt;
   } exp_t;

   logic [7:0] model_q [$];
   bit         model_ovf;
   logic [7:0] model_sel;
   exp_t       exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         lat_cal = 0;

   function automatic logic [7:0] model_read();
      int n;
      n = model_q.size();
      if (model_sel == 8'd1) return (n > 0) ? model_q[0] : 8'h00;
      if (model_sel == 8'd2) return {(n > 0), model_ovf, (n == DEPTH), 1'b0, 4'(n)};
      return 8'h00;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sclk);
         #1;
      end
   endtask

   task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check_output({tag, " count"}, 16'(count), 16'(model_q.size()));
      check_output({tag, " overflow"}, 16'(overflow), 16'(model_ovf));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      model_q.delete();
      model_ovf = 1'b0;
      model_sel = 8'h00;
   endtask

   task automatic do_select(input logic [7:0] a);
      io.io_da  = 1'b1;
      io.io_io  = 1'b1;
      io.io_s   = 1'b1;
      io.bus_in = a;
      tick(1);
      io.io_s  = 1'b0;
      io.io_da = 1'b0;
      io.io_io = 1'b0;
      tick(1);
      model_sel = a;
   endtask

   task automatic do_read(input int len);
      exp_t e;
      e.bus = model_read();
      e.cnt = model_q.size();
      exp_q.push_back(e);
      io.io_da = 1'b0;
      io.io_io = 1'b0;
      io.io_e  = 1'b1;
      tick(len);
      io.io_e = 1'b0;
      tick(2);
      if (model_sel == 8'd1 && model_q.size() > 0) void'(model_q.pop_front());
      else if (model_sel == 8'd2) model_ovf = 1'b0;
   endtask

   task automatic do_press(input logic [7:0] b, input int bounces, output int lat);
      logic [2:0] c0;
      sw_data = b;
      for (int i = 0; i < bounces; i++) begin
         btn_push = 1'b1;
         tick(1);
         btn_push = 1'b0;
         tick(1);
      end
      c0 = count;
      btn_push = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         if (lat == 0 && count != c0) lat = i;
      end
      btn_push = 1'b0;
      tick(8);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else model_ovf = 1'b1;
   endtask

   task automatic apply_stimulus(input int op);
      logic [7:0] addrs [4];
      int         lat;
      addrs[0] = 8'd1; addrs[1] = 8'd2; addrs[2] = 8'd0; addrs[3] = 8'd7;
      case (op)
         0:       do_press(8'($urandom), $urandom_range(0, 2), lat);
         1:       do_select(addrs[$urandom_range(0, 3)]);
         default: do_read($urandom_range(1, 6));
      endcase
   endtask

   // Monitor: one expected entry per IN Data window, held for the whole window.
   exp_t cur;
   bit   was_rd = 1'b0;
   bit   in_rd;
   always @(negedge sclk) begin
      in_rd = io.io_e && !io.io_da && !io.io_io;
      if (reset) begin
         was_rd = 1'b0;
      end else begin
         if (in_rd) begin
            if (!was_rd) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL read_window got unexpected read want none at %0t", $time);
                  cur.bus = 8'h00;
                  cur.cnt = 0;
               end else begin
                  cur = exp_q.pop_front();
               end
               check_output("read count", 16'(count), 16'(cur.cnt));
            end
            check_output("read bus_out", 16'(io.bus_out), 16'(cur.bus));
         end else begin
            check_output("idle bus_out", 16'(io.bus_out), 16'h0000);
         end
         was_rd = in_rd;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] nb;
      int         lat;
      exp_t       e;
      reset     = 1'b1;
      sw_data   = 8'h00;
      btn_push  = 1'b0;
      io.io_s   = 1'b0;
      io.io_e   = 1'b0;
      io.io_da  = 1'b0;
      io.io_io  = 1'b0;
      io.bus_in = 8'h00;
      model_ovf = 1'b0;
      model_sel = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(1);
      check_state("reset");

      do_select(8'd2);
      do_read(3);
      check_state("empty stat");

      do_press(8'h2A, 3, lat);
      check_state("bounce push");
      do_read(2);

      do_reset();
      do_press(8'h11, 0, lat_cal);
      do_press(8'h22, 0, lat);
      do_press(8'h33, 0, lat);
      check_state("three pushes");
      if (lat_cal < 2) begin
         check_output("push latency", 16'(lat_cal), 16'd2);
         lat_cal = 5;
      end
      do_select(8'd1);
      repeat (3) do_read(5);
      check_state("three pops");

      do_reset();
      repeat (5) do_press(8'($urandom), 0, lat);
      check_state("overfill");
      do_select(8'd2);
      do_read(4);
      check_state("stat clear");
      do_read(2);

      // Full FIFO: line the push pulse up with a DATA read-end.
      do_select(8'd1);
      nb = 8'($urandom);
      e.bus = model_read();
      e.cnt = model_q.size();
      exp_q.push_back(e);
      io.io_e = 1'b1;
      tick(2);
      sw_data  = nb;
      btn_push = 1'b1;
      tick(lat_cal - 1);
      io.io_e = 1'b0;
      tick(6);
      btn_push = 1'b0;
      tick(8);
      void'(model_q.pop_front());
      model_q.push_back(nb);
      check_state("push with pop");
      repeat (4) do_read(3);
      check_state("drained");

      do_press(8'h5A, 0, lat);
      do_press(8'hA5, 0, lat);
      do_reset();
      check_state("mid reset");
      do_read(3);

      for (int i = 0; i < 40; i++) begin
         apply_stimulus($urandom_range(0, 3));
         check_state("random");
      end

      tick(4);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL pending_reads got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
